// File: rtl/local_move_best_selector_pkg.sv
// Shared widths, FSM encoding and tie-break constants for the streaming best-move selector.
package local_move_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam int TIE_LOWEST = 0;
   localparam int TIE_RANDOM = 1;

   function automatic int gain_w(input int clause_idx_w);
      return clause_idx_w + 1;
   endfunction

   function automatic int int_w(input int int_idx_w, input int int_var_w);
      return (1 << int_idx_w) * int_var_w;
   endfunction

   function automatic int bool_w(input int bool_idx_w);
      return 1 << bool_idx_w;
   endfunction

   function automatic int cnt_w(input int num_candidates);
      return $clog2(num_candidates + 1);
   endfunction

endpackage

// File: rtl/local_move_best_selector_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), stepped once per accepted beat.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        in_clk,
   input  logic        in_reset,
   input  logic        in_step,
   output logic [15:0] out_state
);

   logic [15:0] r_state;
   logic        w_fb;

   assign w_fb      = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];
   assign out_state = r_state;

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_state <= SEED;
      end else if (in_step) begin
         r_state <= {w_fb, r_state[15:1]};
      end
   end

endmodule

// File: rtl/local_move_best_selector.sv
// Streaming best-move selector: folds LANES candidates per beat into a running best,
// then reports best gain/index/assignment with a one-cycle done pulse.
module local_move_best_selector
   import local_move_pkg::*;
#(
   parameter int          INT_IDX_W      = 1,
   parameter int          BOOL_IDX_W     = 1,
   parameter int          INT_VAR_W      = 4,
   parameter int          CLAUSE_IDX_W   = 2,
   parameter int          NUM_CANDIDATES = 4,
   parameter int          LANES          = 2,
   parameter int          TIE_MODE       = 0,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   localparam int         GAIN_W         = gain_w(CLAUSE_IDX_W),
   localparam int         INT_W          = int_w(INT_IDX_W, INT_VAR_W),
   localparam int         BOOL_W         = bool_w(BOOL_IDX_W),
   localparam int         CNT_W          = cnt_w(NUM_CANDIDATES)
) (
   input  logic                    in_clk,
   input  logic                    in_reset,
   input  logic                    in_start,
   input  logic                    in_abort,
   input  logic [CNT_W-1:0]        in_num_candidates,
   input  logic [GAIN_W-1:0]       in_current_gain,
   input  logic                    in_cand_valid,
   output logic                    out_cand_ready,
   input  logic [LANES-1:0]        in_cand_lane_valid,
   input  logic [LANES*GAIN_W-1:0] in_cand_gains,
   input  logic [LANES*INT_W-1:0]  in_cand_int,
   input  logic [LANES*BOOL_W-1:0] in_cand_bool,
   output logic                    out_busy,
   output logic                    out_done,
   output logic [GAIN_W-1:0]       out_best_gain,
   output logic [CNT_W-1:0]        out_best_index,
   output logic [INT_W-1:0]        out_best_assignment_integer,
   output logic [BOOL_W-1:0]       out_best_assignment_boolean,
   output logic                    out_improved,
   output logic                    out_none_valid
);

   localparam int IW = CNT_W + $clog2(LANES + 1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_count, r_num;
   logic [GAIN_W-1:0]   r_cur_gain;
   logic                r_best_valid;
   logic [GAIN_W-1:0]   r_best_gain;
   logic [CNT_W-1:0]    r_best_idx;
   logic [INT_W-1:0]    r_best_int;
   logic [BOOL_W-1:0]   r_best_bool;
   logic                r_done, r_improved, r_none_valid;
   logic [GAIN_W-1:0]   r_out_gain;
   logic [CNT_W-1:0]    r_out_idx;
   logic [INT_W-1:0]    r_out_int;
   logic [BOOL_W-1:0]   r_out_bool;

   logic [15:0]         w_lfsr;
   logic                w_unused_lfsr;
   logic                w_accept, w_last;
   logic [IW-1:0]       w_sum;
   logic [CNT_W-1:0]    w_count_next;
   logic                w_fin_improved;

   logic                w_fv [0:LANES];
   logic [GAIN_W-1:0]   w_fg [0:LANES];
   logic [CNT_W-1:0]    w_fi [0:LANES];
   logic [INT_W-1:0]    w_fint [0:LANES];
   logic [BOOL_W-1:0]   w_fbool [0:LANES];

   // A beat transfers on a cycle where in_cand_valid and out_cand_ready are both high;
   // ready depends only on state, and abort in the same cycle cancels the transfer.
   assign out_cand_ready = (r_state == ST_COLLECT);
   assign out_busy       = (r_state != ST_IDLE);
   assign w_accept       = in_cand_valid && (r_state == ST_COLLECT) && !in_abort;

   assign w_sum        = IW'(r_count) + IW'(LANES);
   assign w_last       = (w_sum >= IW'(r_num));
   assign w_count_next = w_last ? r_num : w_sum[CNT_W-1:0];

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .in_clk    (in_clk),
      .in_reset  (in_reset),
      .in_step   (w_accept),
      .out_state (w_lfsr)
   );
   assign w_unused_lfsr = ^w_lfsr;

   assign w_fv[0]    = r_best_valid;
   assign w_fg[0]    = r_best_gain;
   assign w_fi[0]    = r_best_idx;
   assign w_fint[0]  = r_best_int;
   assign w_fbool[0] = r_best_bool;

   // Lanes fold in ascending index order so TIE_LOWEST keeps the earliest equal gain.
   for (genvar l = 0; l < LANES; l++) begin : g_fold
      logic [GAIN_W-1:0] w_gain;
      logic [IW-1:0]     w_idx;
      logic              w_counts, w_tie, w_take;

      assign w_gain   = in_cand_gains[l*GAIN_W +: GAIN_W];
      assign w_idx    = IW'(r_count) + IW'(l);
      assign w_counts = in_cand_lane_valid[l] && (w_idx < IW'(r_num));
      assign w_tie    = (TIE_MODE == TIE_RANDOM) && w_lfsr[l % 16];
      assign w_take   = w_counts && (!w_fv[l] || (w_gain > w_fg[l]) ||
                                     ((w_gain == w_fg[l]) && w_tie));

      assign w_fv[l+1]    = w_fv[l] || w_counts;
      assign w_fg[l+1]    = w_take ? w_gain : w_fg[l];
      assign w_fi[l+1]    = w_take ? w_idx[CNT_W-1:0] : w_fi[l];
      assign w_fint[l+1]  = w_take ? in_cand_int[l*INT_W +: INT_W] : w_fint[l];
      assign w_fbool[l+1] = w_take ? in_cand_bool[l*BOOL_W +: BOOL_W] : w_fbool[l];
   end

   assign w_fin_improved = w_fv[LANES] && (w_fg[LANES] > r_cur_gain);

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_num        <= '0;
         r_cur_gain   <= '0;
         r_best_valid <= 1'b0;
         r_best_gain  <= '0;
         r_best_idx   <= '0;
         r_best_int   <= '0;
         r_best_bool  <= '0;
         r_done       <= 1'b0;
         r_improved   <= 1'b0;
         r_none_valid <= 1'b0;
         r_out_gain   <= '0;
         r_out_idx    <= '0;
         r_out_int    <= '0;
         r_out_bool   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (in_start) begin
                  r_num        <= in_num_candidates;
                  r_cur_gain   <= in_current_gain;
                  r_count      <= '0;
                  r_best_valid <= 1'b0;
                  r_best_gain  <= '0;
                  r_best_idx   <= '0;
                  r_best_int   <= '0;
                  r_best_bool  <= '0;
                  if (in_num_candidates == '0) begin
                     r_state      <= ST_DONE;
                     r_done       <= 1'b1;
                     r_none_valid <= 1'b1;
                     r_improved   <= 1'b0;
                     r_out_gain   <= '0;
                     r_out_idx    <= '0;
                     r_out_int    <= '0;
                     r_out_bool   <= '0;
                  end else begin
                     r_state <= ST_COLLECT;
                  end
               end
            end
            ST_COLLECT: begin
               if (in_abort) begin
                  r_state <= ST_IDLE;
               end else if (w_accept) begin
                  r_count      <= w_count_next;
                  r_best_valid <= w_fv[LANES];
                  r_best_gain  <= w_fg[LANES];
                  r_best_idx   <= w_fi[LANES];
                  r_best_int   <= w_fint[LANES];
                  r_best_bool  <= w_fbool[LANES];
                  if (w_last) begin
                     r_state      <= ST_DONE;
                     r_done       <= 1'b1;
                     r_none_valid <= !w_fv[LANES];
                     r_improved   <= w_fin_improved;
                     r_out_gain   <= w_fg[LANES];
                     r_out_idx    <= w_fi[LANES];
                     r_out_int    <= w_fint[LANES];
                     r_out_bool   <= w_fbool[LANES];
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_done                    = r_done;
   assign out_best_gain               = r_out_gain;
   assign out_best_index              = r_out_idx;
   assign out_best_assignment_integer = r_out_int;
   assign out_best_assignment_boolean = r_out_bool;
   assign out_improved                = r_improved;
   assign out_none_valid              = r_none_valid;

endmodule

// File: tb/tb_local_move_best_selector.sv
// Bench for local_move_best_selector: one lowest-index and one LFSR tie-break instance share stimulus.
module tb_local_move_best_selector;

   localparam int LANES  = 2;
   localparam int GAIN_W = 3;
   localparam int INT_W  = 8;
   localparam int BOOL_W = 2;
   localparam int CNT_W  = 3;
   localparam int MAXB   = 4;
   localparam int RW     = 2 + GAIN_W + CNT_W + INT_W + BOOL_W;
   localparam logic [15:0] SEED = 16'hACE1;

   logic                    in_clk = 1'b0;
   logic                    in_reset = 1'b0;
   logic                    in_start = 1'b0;
   logic                    in_abort = 1'b0;
   logic [CNT_W-1:0]        in_num_candidates = '0;
   logic [GAIN_W-1:0]       in_current_gain = '0;
   logic                    in_cand_valid = 1'b0;
   logic [LANES-1:0]        in_cand_lane_valid = '0;
   logic [LANES*GAIN_W-1:0] in_cand_gains = '0;
   logic [LANES*INT_W-1:0]  in_cand_int = '0;
   logic [LANES*BOOL_W-1:0] in_cand_bool = '0;

   logic                lo_ready, lo_busy, lo_done, lo_improved, lo_none;
   logic [GAIN_W-1:0]   lo_gain;
   logic [CNT_W-1:0]    lo_idx;
   logic [INT_W-1:0]    lo_int;
   logic [BOOL_W-1:0]   lo_bool;
   logic                rn_ready, rn_busy, rn_done, rn_improved, rn_none;
   logic [GAIN_W-1:0]   rn_gain;
   logic [CNT_W-1:0]    rn_idx;
   logic [INT_W-1:0]    rn_int;
   logic [BOOL_W-1:0]   rn_bool;

   local_move_best_selector #(.TIE_MODE(0)) dut_lo (
      .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
      .in_num_candidates(in_num_candidates), .in_current_gain(in_current_gain),
      .in_cand_valid(in_cand_valid), .out_cand_ready(lo_ready),
      .in_cand_lane_valid(in_cand_lane_valid), .in_cand_gains(in_cand_gains),
      .in_cand_int(in_cand_int), .in_cand_bool(in_cand_bool),
      .out_busy(lo_busy), .out_done(lo_done), .out_best_gain(lo_gain),
      .out_best_index(lo_idx), .out_best_assignment_integer(lo_int),
      .out_best_assignment_boolean(lo_bool), .out_improved(lo_improved),
      .out_none_valid(lo_none)
   );

   local_move_best_selector #(.TIE_MODE(1)) dut_rn (
      .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
      .in_num_candidates(in_num_candidates), .in_current_gain(in_current_gain),
      .in_cand_valid(in_cand_valid), .out_cand_ready(rn_ready),
      .in_cand_lane_valid(in_cand_lane_valid), .in_cand_gains(in_cand_gains),
      .in_cand_int(in_cand_int), .in_cand_bool(in_cand_bool),
      .out_busy(rn_busy), .out_done(rn_done), .out_best_gain(rn_gain),
      .out_best_index(rn_idx), .out_best_assignment_integer(rn_int),
      .out_best_assignment_boolean(rn_bool), .out_improved(rn_improved),
      .out_none_valid(rn_none)
   );

   // clock / reset
   always #5 in_clk = ~in_clk;

   int total = 0;
   int bad   = 0;

   logic [15:0]       m_lfsr = SEED;
   logic [LANES-1:0]  t_lv [MAXB];
   logic [GAIN_W-1:0] t_g [MAXB][LANES];
   logic [INT_W-1:0]  t_i [MAXB][LANES];
   logic [BOOL_W-1:0] t_b [MAXB][LANES];

   // scoreboard: {none_valid, improved, gain, index, int, bool}
   logic [RW-1:0] exp_lo_q[$];
   logic [RW-1:0] exp_rn_q[$];
   logic [RW-1:0] last_lo;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      int v, fb;
      v  = int'(s);
      fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      return 16'((v >> 1) | (fb << 15));
   endfunction

   // Reference: scan candidates in index order with the tie rule of each instance.
   task automatic model(input int num, input int cur, input int nb);
      logic [15:0] s;
      for (int mode = 0; mode < 2; mode++) begin
         int bv, bg, bi, bint, bbool;
         bv = 0; bg = 0; bi = 0; bint = 0; bbool = 0;
         s = m_lfsr;
         for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < LANES; l++) begin
               int idx, g, tie;
               idx = b * LANES + l;
               g   = int'(t_g[b][l]);
               tie = (mode == 1) ? ((int'(s) >> (l % 16)) & 1) : 0;
               if (t_lv[b][l] && idx < num) begin
                  if (bv == 0 || g > bg || (g == bg && tie == 1)) begin
                     bg = g; bi = idx; bint = int'(t_i[b][l]); bbool = int'(t_b[b][l]);
                  end
                  bv = 1;
               end
            end
            s = lfsr_next(s);
         end
         if (mode == 0)
            exp_lo_q.push_back({(bv == 0), (bv == 1 && bg > cur), GAIN_W'(bg), CNT_W'(bi),
                                INT_W'(bint), BOOL_W'(bbool)});
         else
            exp_rn_q.push_back({(bv == 0), (bv == 1 && bg > cur), GAIN_W'(bg), CNT_W'(bi),
                                INT_W'(bint), BOOL_W'(bbool)});
      end
      m_lfsr = s;
   endtask

   task automatic check_result();
      logic [RW-1:0] e;
      e = exp_lo_q.pop_front();
      last_lo = e;
      check("lo_none", lo_none, e[RW-1]);
      check("lo_improved", lo_improved, e[RW-2]);
      check("lo_gain", lo_gain, e[RW-3 -: GAIN_W]);
      check("lo_index", lo_idx, e[RW-3-GAIN_W -: CNT_W]);
      check("lo_int", lo_int, e[INT_W+BOOL_W-1 -: INT_W]);
      check("lo_bool", lo_bool, e[BOOL_W-1:0]);
      e = exp_rn_q.pop_front();
      check("rn_none", rn_none, e[RW-1]);
      check("rn_improved", rn_improved, e[RW-2]);
      check("rn_gain", rn_gain, e[RW-3 -: GAIN_W]);
      check("rn_index", rn_idx, e[RW-3-GAIN_W -: CNT_W]);
      check("rn_int", rn_int, e[INT_W+BOOL_W-1 -: INT_W]);
      check("rn_bool", rn_bool, e[BOOL_W-1:0]);
   endtask

   task automatic set_lane(input int b, input int l, input logic lv, input int g);
      t_lv[b][l] = lv;
      t_g[b][l]  = GAIN_W'(g);
      t_i[b][l]  = INT_W'($urandom_range(255, 0));
      t_b[b][l]  = BOOL_W'($urandom_range(3, 0));
   endtask

   task automatic fill_random();
      for (int b = 0; b < MAXB; b++)
         for (int l = 0; l < LANES; l++)
            set_lane(b, l, 1'($urandom_range(3, 0) != 0), int'($urandom_range(7, 0)));
   endtask

   task automatic drive_beat(input int b);
      in_cand_valid      = 1'b1;
      in_cand_lane_valid = t_lv[b];
      for (int l = 0; l < LANES; l++) begin
         in_cand_gains[l*GAIN_W +: GAIN_W] = t_g[b][l];
         in_cand_int[l*INT_W +: INT_W]     = t_i[b][l];
         in_cand_bool[l*BOOL_W +: BOOL_W]  = t_b[b][l];
      end
   endtask

   task automatic start_search(input int num, input int cur);
      @(negedge in_clk);
      in_start          = 1'b1;
      in_num_candidates = CNT_W'(num);
      in_current_gain   = GAIN_W'(cur);
      @(negedge in_clk);
      in_start = 1'b0;
   endtask

   // driver: full search, checking done timing and results
   task automatic run_search(input int num, input int cur, input int gap_max, output int rn_index);
      int nb;
      nb = (num + LANES - 1) / LANES;
      model(num, cur, nb);
      start_search(num, cur);
      if (num == 0) check("zero_ready", lo_ready, 0);
      for (int b = 0; b < nb; b++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            check("gap_done", lo_done, 0);
            @(negedge in_clk);
         end
         drive_beat(b);
         check("beat_ready", lo_ready, 1);
         check("beat_done", lo_done, 0);
         @(negedge in_clk);
         in_cand_valid = 1'b0;
      end
      check("lo_done", lo_done, 1);
      check("rn_done", rn_done, 1);
      check("done_busy", lo_busy, 1);
      rn_index = int'(rn_idx);
      check_result();
      @(negedge in_clk);
      check("done_pulse_end", lo_done, 0);
      check("idle_busy", lo_busy, 0);
   endtask

   initial begin
      int ri;
      logic [3:0] seen;

      // reset state
      repeat (2) @(negedge in_clk);
      check("rst_done", lo_done, 0);
      check("rst_busy", lo_busy, 0);
      check("rst_ready", lo_ready, 0);
      check("rst_gain", lo_gain, 0);
      check("rst_index", lo_idx, 0);
      check("rst_none", lo_none, 0);
      check("rst_improved", rn_improved, 0);
      in_reset = 1'b1;

      // directed: best gain in lane 1 of beat 0
      set_lane(0, 0, 1, 1); set_lane(0, 1, 1, 3);
      set_lane(1, 0, 1, 2); set_lane(1, 1, 1, 0);
      run_search(4, 2, 0, ri);
      check("t1_gain", lo_gain, 3);
      check("t1_index", lo_idx, 1);
      check("t1_improved", lo_improved, 1);

      // directed: all equal gains, lowest index kept
      for (int b = 0; b < 2; b++)
         for (int l = 0; l < LANES; l++) set_lane(b, l, 1, 2);
      run_search(4, 2, 1, ri);
      check("t2_index", lo_idx, 0);
      check("t2_improved", lo_improved, 0);

      // directed: lane index beyond num ignored even with higher gain
      set_lane(0, 0, 1, 1); set_lane(0, 1, 1, 1);
      set_lane(1, 0, 1, 2); set_lane(1, 1, 1, 7);
      run_search(3, 0, 0, ri);
      check("t4_gain", lo_gain, 2);
      check("t4_index", lo_idx, 2);

      // directed: empty search
      run_search(0, 3, 0, ri);
      check("t5_none", lo_none, 1);

      // LFSR tie-break across many searches
      seen = '0;
      for (int n = 0; n < 64; n++) begin
         for (int b = 0; b < 2; b++)
            for (int l = 0; l < LANES; l++) set_lane(b, l, 1, 5);
         run_search(4, int'($urandom_range(7, 0)), 0, ri);
         check("tie_in_range", (ri < 4), 1);
         seen[ri[1:0]] = 1'b1;
      end
      check("tie_varies", ($countones(seen) > 1), 1);

      // randomized searches
      for (int n = 0; n < 24; n++) begin
         fill_random();
         run_search(int'($urandom_range(4, 0)), int'($urandom_range(7, 0)), 2, ri);
      end

      // abort after beat 0: no done, results held
      fill_random();
      start_search(4, 1);
      drive_beat(0);
      @(negedge in_clk);
      in_cand_valid = 1'b0;
      m_lfsr = lfsr_next(m_lfsr);
      in_abort = 1'b1;
      @(negedge in_clk);
      in_abort = 1'b0;
      check("abort_done", lo_done, 0);
      check("abort_busy", lo_busy, 0);
      check("abort_gain_held", lo_gain, last_lo[RW-3 -: GAIN_W]);
      check("abort_index_held", lo_idx, last_lo[RW-3-GAIN_W -: CNT_W]);
      repeat (2) begin
         @(negedge in_clk);
         check("abort_no_done", lo_done | rn_done, 0);
      end

      // async reset mid-collect
      fill_random();
      start_search(4, 0);
      drive_beat(0);
      @(negedge in_clk);
      in_cand_valid = 1'b0;
      #2 in_reset = 1'b0;
      #1;
      check("mrst_busy", lo_busy, 0);
      check("mrst_gain", lo_gain, 0);
      check("mrst_int", lo_int, 0);
      check("mrst_none", rn_none, 0);
      m_lfsr = SEED;
      @(negedge in_clk);
      in_reset = 1'b1;

      for (int n = 0; n < 6; n++) begin
         fill_random();
         run_search(int'($urandom_range(4, 1)), int'($urandom_range(7, 0)), 1, ri);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
